// File: rtl/styler_bus_pkg.sv
// Shared definitions for the styler tile register bus: register map,
// control reset value, host FSM states and the request-to-register packer.
package styler_bus_pkg;

  localparam logic [2:0] ADDR_SCANLINE = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_BMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_BMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_ATTR0    = 3'd4;
  localparam logic [2:0] ADDR_ATTR1    = 3'd5;
  localparam logic [2:0] ADDR_ATTR2    = 3'd6;
  localparam logic [2:0] ADDR_ATTR3    = 3'd7;

  localparam logic [5:0] CTRL_RESET = 6'h3C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_LO,
    ST_RD_HI,
    ST_RESP
  } state_t;

  // Lay a request out as the eight target register bytes, indexed by address.
  function automatic logic [7:0][7:0] pack_regs(
    input logic [3:0]  scanline,
    input logic [5:0]  ctrl,
    input logic [15:0] bitmap,
    input logic [24:0] attr
  );
    logic [7:0][7:0] regs;
    regs[ADDR_SCANLINE] = {4'b0, scanline};
    regs[ADDR_CTRL]     = {2'b0, ctrl};
    regs[ADDR_BMP_LO]   = bitmap[7:0];
    regs[ADDR_BMP_HI]   = bitmap[15:8];
    regs[ADDR_ATTR0]    = attr[7:0];
    regs[ADDR_ATTR1]    = attr[15:8];
    regs[ADDR_ATTR2]    = attr[23:16];
    regs[ADDR_ATTR3]    = {7'b0, attr[24]};
    return regs;
  endfunction

endpackage

// File: rtl/styler_dirty_pick.sv
// Lowest-set-bit picker over the 8-entry dirty mask.
module styler_dirty_pick (
  input  logic [7:0] i_mask,
  output logic [2:0] o_idx,
  output logic       o_any
);

  // Scan upward and keep the first set bit found.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i_mask[i] && !o_any) begin
        o_idx = 3'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/styler_host_master.sv
// Host-side initiator for the styler tile: writes only changed registers,
// reads back the styled bitmap in two byte reads, returns it via valid/ready.
module styler_host_master #(
  parameter int unsigned READ_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_scanline,
  input  logic [15:0] req_bitmap,
  input  logic [24:0] req_attr,
  input  logic [5:0]  req_ctrl,
  input  logic [2:0]  req_phase,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_bitmap,
  output logic [2:0]  bus_addr,
  output logic [2:0]  bus_phase,
  output logic        bus_hold_n,
  output logic        bus_we_n,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  import styler_bus_pkg::*;

  localparam int unsigned WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT);

  state_t            r_state, w_state;
  logic              r_shadow_valid, w_shadow_valid;
  logic [7:0][7:0]   r_shadow, w_shadow;
  logic [7:0][7:0]   r_req, w_req;
  logic [7:0]        r_dirty, w_dirty;
  logic [WAIT_W-1:0] r_wait, w_wait;
  logic              r_armed, w_armed;
  logic [2:0]        r_bus_addr, w_bus_addr;
  logic [2:0]        r_bus_phase, w_bus_phase;
  logic              r_bus_hold_n;
  logic              r_bus_we_n, w_bus_we_n;
  logic [7:0]        r_bus_wdata, w_bus_wdata;
  logic              r_rsp_valid, w_rsp_valid;
  logic [15:0]       r_rsp_bitmap, w_rsp_bitmap;

  logic [7:0][7:0]   w_req_bytes;
  logic [7:0]        w_new_dirty;
  logic [2:0]        w_pick_idx;
  logic              w_pick_any;

  assign w_req_bytes = pack_regs(req_scanline, req_ctrl, req_bitmap, req_attr);

  styler_dirty_pick u_pick (
    .i_mask (r_dirty),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Mark every register whose requested byte differs from what the target holds.
  always_comb begin
    w_new_dirty = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_new_dirty[i] = !r_shadow_valid || flush || (w_req_bytes[i] != r_shadow[i]);
    end
  end

  // Next-state and next-output decode; bus outputs change one edge after the
  // state that requests them, so a read entered straight from IDLE first
  // spends an edge putting its address out (r_armed low).
  always_comb begin
    w_state        = r_state;
    w_req          = r_req;
    w_dirty        = r_dirty;
    w_wait         = r_wait;
    w_armed        = r_armed;
    w_bus_addr     = r_bus_addr;
    w_bus_phase    = r_bus_phase;
    w_bus_we_n     = 1'b1;
    w_bus_wdata    = r_bus_wdata;
    w_rsp_valid    = r_rsp_valid;
    w_rsp_bitmap   = r_rsp_bitmap;
    w_shadow_valid = r_shadow_valid && !flush;
    w_shadow       = r_shadow;
    if (!r_bus_we_n) begin
      w_shadow[r_bus_addr] = r_bus_wdata;
    end

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_req       = w_req_bytes;
          w_dirty     = w_new_dirty;
          w_bus_phase = req_phase;
          w_armed     = 1'b0;
          w_wait      = '0;
          w_state     = (|w_new_dirty) ? ST_WRITE : ST_RD_LO;
        end
      end
      ST_WRITE: begin
        if (w_pick_any) begin
          w_bus_addr          = w_pick_idx;
          w_bus_wdata         = r_req[w_pick_idx];
          w_bus_we_n          = 1'b0;
          w_dirty[w_pick_idx] = 1'b0;
        end else begin
          w_bus_addr = ADDR_BMP_LO;
          w_armed    = 1'b1;
          w_wait     = '0;
          w_state    = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        if (!r_armed) begin
          w_bus_addr = ADDR_BMP_LO;
          w_armed    = 1'b1;
          w_wait     = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_rsp_bitmap[7:0] = bus_rdata;
          w_bus_addr        = ADDR_BMP_HI;
          w_wait            = '0;
          w_state           = ST_RD_HI;
        end else begin
          w_wait = r_wait + WAIT_W'(1);
        end
      end
      ST_RD_HI: begin
        if (r_wait == WAIT_LAST) begin
          w_rsp_bitmap[15:8] = bus_rdata;
          w_rsp_valid        = 1'b1;
          w_shadow_valid     = !flush;
          w_state            = ST_RESP;
        end else begin
          w_wait = r_wait + WAIT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and registered-output update with asynchronous abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_shadow_valid <= 1'b0;
      r_shadow       <= '0;
      r_req          <= '0;
      r_dirty        <= '0;
      r_wait         <= '0;
      r_armed        <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_phase    <= '0;
      r_bus_hold_n   <= 1'b1;
      r_bus_we_n     <= 1'b1;
      r_bus_wdata    <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_bitmap   <= '0;
    end else begin
      r_state        <= w_state;
      r_shadow_valid <= w_shadow_valid;
      r_shadow       <= w_shadow;
      r_req          <= w_req;
      r_dirty        <= w_dirty;
      r_wait         <= w_wait;
      r_armed        <= w_armed;
      r_bus_addr     <= w_bus_addr;
      r_bus_phase    <= w_bus_phase;
      r_bus_hold_n   <= 1'b1;
      r_bus_we_n     <= w_bus_we_n;
      r_bus_wdata    <= w_bus_wdata;
      r_rsp_valid    <= w_rsp_valid;
      r_rsp_bitmap   <= w_rsp_bitmap;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_bitmap = r_rsp_bitmap;
  assign bus_addr   = r_bus_addr;
  assign bus_phase  = r_bus_phase;
  assign bus_hold_n = r_bus_hold_n;
  assign bus_we_n   = r_bus_we_n;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_styler_host_master.sv
// Bench for styler_host_master: two instances (READ_WAIT 0 and 2), each on a
// behavioural styler target; expected bitmaps go through a scoreboard queue.
module tb_styler_host_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [3:0]  req_scanline [2];
  logic [15:0] req_bitmap [2];
  logic [24:0] req_attr [2];
  logic [5:0]  req_ctrl [2];
  logic [2:0]  req_phase [2];
  logic        flush [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_bitmap [2];
  logic [2:0]  bus_addr [2];
  logic [2:0]  bus_phase [2];
  logic        bus_hold_n [2];
  logic        bus_we_n [2];
  logic [7:0]  bus_wdata [2];
  logic [7:0]  bus_rdata [2];

  styler_host_master #(.READ_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_scanline(req_scanline[0]), .req_bitmap(req_bitmap[0]),
    .req_attr(req_attr[0]), .req_ctrl(req_ctrl[0]), .req_phase(req_phase[0]),
    .flush(flush[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_bitmap(rsp_bitmap[0]), .bus_addr(bus_addr[0]), .bus_phase(bus_phase[0]),
    .bus_hold_n(bus_hold_n[0]), .bus_we_n(bus_we_n[0]),
    .bus_wdata(bus_wdata[0]), .bus_rdata(bus_rdata[0])
  );

  styler_host_master #(.READ_WAIT(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_scanline(req_scanline[1]), .req_bitmap(req_bitmap[1]),
    .req_attr(req_attr[1]), .req_ctrl(req_ctrl[1]), .req_phase(req_phase[1]),
    .flush(flush[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_bitmap(rsp_bitmap[1]), .bus_addr(bus_addr[1]), .bus_phase(bus_phase[1]),
    .bus_hold_n(bus_hold_n[1]), .bus_we_n(bus_we_n[1]),
    .bus_wdata(bus_wdata[1]), .bus_rdata(bus_rdata[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q [$];
  logic [7:0][7:0] m_shadow [2];
  bit              m_valid [2];
  logic [2:0]      addr_trace [64];
  int              trace_len;

  // Behavioural styling the target applies to its register contents.
  function automatic logic [15:0] exp_style(input logic [3:0] scan, input logic [15:0] bmp,
                                            input logic [24:0] attr, input logic [5:0] ctrl,
                                            input logic [2:0] ph);
    return bmp ^ attr[15:0] ^ {attr[23:16], 3'b000, attr[24], scan} ^ {ctrl, 7'b0, ph};
  endfunction

  function automatic logic [7:0][7:0] pack(input logic [3:0] scan, input logic [5:0] ctrl,
                                           input logic [15:0] bmp, input logic [24:0] attr);
    logic [7:0][7:0] r;
    r[0] = {4'b0, scan};
    r[1] = {2'b0, ctrl};
    r[2] = bmp[7:0];
    r[3] = bmp[15:8];
    r[4] = attr[7:0];
    r[5] = attr[15:8];
    r[6] = attr[23:16];
    r[7] = {7'b0, attr[24]};
    return r;
  endfunction

  function automatic logic [7:0] tgt_read(input logic [7:0][7:0] regs, input logic [2:0] a,
                                          input logic [2:0] ph);
    logic [15:0] s;
    s = exp_style(regs[0][3:0], {regs[3], regs[2]}, {regs[7][0], regs[6], regs[5], regs[4]},
                  regs[1][5:0], ph);
    if (a == 3'd2) return s[7:0];
    if (a == 3'd3) return s[15:8];
    return regs[a];
  endfunction

  // Target register file: not reset, keeps whatever it was written.
  logic [7:0][7:0] tgt [2];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (bus_we_n[u] === 1'b0) tgt[u][bus_addr[u]] <= bus_wdata[u];
    end
  end
  assign bus_rdata[0] = tgt_read(tgt[0], bus_addr[0], bus_phase[0]);
  assign bus_rdata[1] = tgt_read(tgt[1], bus_addr[1], bus_phase[1]);

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_req(input int u, input logic [3:0] scan, input logic [15:0] bmp,
                        input logic [24:0] attr, input logic [5:0] ctrl, input logic [2:0] ph,
                        input bit fl, input int exp_k, input int exp_lat, input int bp,
                        input string name);
    logic [7:0][7:0] nb;
    logic [2:0] ea [$];
    logic [7:0] ed [$];
    logic [15:0] exp_bm;
    int A, E, nw;
    bit acc, r;
    nb = pack(scan, ctrl, bmp, attr);
    for (int i = 0; i < 8; i++) begin
      if (!m_valid[u] || fl || nb[i] != m_shadow[u][i]) begin
        ea.push_back(3'(i));
        ed.push_back(nb[i]);
      end
    end
    exp_q.push_back(exp_style(scan, bmp, attr, ctrl, ph));
    @(negedge clk);
    rsp_ready[u] = (bp == 0);
    req_scanline[u] = scan; req_bitmap[u] = bmp; req_attr[u] = attr;
    req_ctrl[u] = ctrl; req_phase[u] = ph; flush[u] = fl; req_valid[u] = 1'b1;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      r = req_ready[u];
      @(posedge clk); #1;
      if (r) acc = 1;
      else @(negedge clk);
    end
    A = cyc;
    req_valid[u] = 1'b0; flush[u] = 1'b0;
    n_checks++;
    if (acc !== 1'b1) begin n_errors++; $display("FAIL %s accept got %0d exp 1", name, acc); end
    E = -1; nw = 0; trace_len = 0;
    for (int t = 0; t < 60 && E < 0; t++) begin
      @(posedge clk); #1;
      if (trace_len < 64) begin addr_trace[trace_len] = bus_addr[u]; trace_len++; end
      if (bus_we_n[u] === 1'b0) begin
        if (nw < ea.size()) begin
          n_checks++;
          if (bus_addr[u] !== ea[nw] || bus_wdata[u] !== ed[nw]) begin
            n_errors++;
            $display("FAIL %s write%0d got a=%0d d=%h exp a=%0d d=%h", name, nw,
                     bus_addr[u], bus_wdata[u], ea[nw], ed[nw]);
          end
        end
        nw++;
      end
      if (rsp_valid[u] === 1'b1) E = cyc;
    end
    n_checks++;
    if (nw !== exp_k || nw !== ea.size()) begin
      n_errors++;
      $display("FAIL %s nwrites got %0d exp %0d model %0d", name, nw, exp_k, ea.size());
    end
    n_checks++;
    if (E < 0 || (E - A) !== exp_lat) begin
      n_errors++;
      $display("FAIL %s latency got %0d exp %0d", name, (E < 0) ? -1 : E - A, exp_lat);
    end
    exp_bm = exp_q.pop_front();
    n_checks++;
    if (rsp_bitmap[u] !== exp_bm) begin
      n_errors++; $display("FAIL %s rsp_bitmap got %h exp %h", name, rsp_bitmap[u], exp_bm);
    end
    m_shadow[u] = nb; m_valid[u] = 1'b1;
    for (int t = 0; t < bp; t++) begin
      if (t == 1) begin
        req_scanline[u] = 4'hF; req_bitmap[u] = 16'hFFFF; req_attr[u] = '1;
        req_ctrl[u] = 6'h3F; req_valid[u] = 1'b1;
      end
      if (t == 2) req_valid[u] = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_bitmap[u] !== exp_bm || req_ready[u] !== 1'b0) begin
        n_errors++;
        $display("FAIL %s hold%0d got v=%b bm=%h rdy=%b exp v=1 bm=%h rdy=0", name, t,
                 rsp_valid[u], rsp_bitmap[u], req_ready[u], exp_bm);
      end
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    for (int t = 0; t < 10 && rsp_valid[u] === 1'b1; t++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s release got v=%b rdy=%b exp v=0 rdy=1", name, rsp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (bus_addr[u] !== 3'd0 || bus_phase[u] !== 3'd0 || bus_wdata[u] !== 8'd0) begin
        n_errors++;
        $display("FAIL reset_bus%0d got a=%0d p=%0d d=%h exp 0 0 00", u, bus_addr[u],
                 bus_phase[u], bus_wdata[u]);
      end
      n_checks++;
      if (bus_hold_n[u] !== 1'b1 || bus_we_n[u] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_ctl%0d got hold_n=%b we_n=%b exp 1 1", u, bus_hold_n[u], bus_we_n[u]);
      end
      n_checks++;
      if (rsp_valid[u] !== 1'b0 || rsp_bitmap[u] !== 16'h0 || req_ready[u] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_rsp%0d got v=%b bm=%h rdy=%b exp 0 0000 1", u, rsp_valid[u],
                 rsp_bitmap[u], req_ready[u]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
  endtask

  task automatic test_dirty_writes();
    do_req(0, 4'd5, 16'h3C7E, 25'd0, 6'h3C, 3'd0, 1'b0, 8, 11, 0, "full");
    do_req(0, 4'd5, 16'h3C7E, 25'd0, 6'h3C, 3'd0, 1'b0, 0, 3, 0, "clean");
    do_req(0, 4'd5, 16'h3C7E, 25'h1000000, 6'h3C, 3'd0, 1'b0, 1, 4, 0, "attr24");
  endtask

  task automatic test_backpressure();
    bit quiet;
    do_req(0, 4'd5, 16'h3C7E, 25'h1000000, 6'h3C, 3'b101, 1'b0, 0, 3, 5, "backpressure");
    quiet = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      if (bus_we_n[0] !== 1'b1 || rsp_valid[0] !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin n_errors++; $display("FAIL ghost_request got activity exp none"); end
    do_req(0, 4'd5, 16'h3C7E, 25'h1000000, 6'h3C, 3'd0, 1'b0, 0, 3, 0, "after_ghost");
  endtask

  task automatic test_read_wait();
    bit ok;
    logic [2:0] want [6];
    want[0] = 3'd2; want[1] = 3'd2; want[2] = 3'd2;
    want[3] = 3'd3; want[4] = 3'd3; want[5] = 3'd3;
    do_req(1, 4'd3, 16'hA55A, 25'h0123456, 6'h15, 3'd2, 1'b0, 8, 15, 0, "rw2_full");
    do_req(1, 4'd3, 16'hA55A, 25'h0123456, 6'h15, 3'd6, 1'b0, 0, 7, 0, "rw2_clean");
    ok = (trace_len >= 6);
    for (int i = 0; i < 6 && ok; i++) if (addr_trace[i] !== want[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rw2_addr_hold got %0d%0d%0d%0d%0d%0d exp 222333", addr_trace[0],
               addr_trace[1], addr_trace[2], addr_trace[3], addr_trace[4], addr_trace[5]);
    end
  endtask

  task automatic test_abort();
    int nw;
    @(negedge clk);
    req_scanline[0] = 4'd9; req_bitmap[0] = 16'h1234; req_attr[0] = 25'h1000000;
    req_ctrl[0] = 6'h2A; req_phase[0] = 3'd1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    nw = 0;
    for (int t = 0; t < 20 && nw < 3; t++) begin
      @(posedge clk); #1;
      if (bus_we_n[0] === 1'b0) nw++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (nw !== 3 || bus_we_n[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL abort got writes=%0d we_n=%b v=%b rdy=%b exp 3 1 0 1", nw, bus_we_n[0],
               rsp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    do_req(0, 4'd9, 16'h1234, 25'h1000000, 6'h2A, 3'd1, 1'b0, 8, 11, 0, "post_abort");
  endtask

  task automatic test_flush();
    do_req(0, 4'd9, 16'h1234, 25'h1000000, 6'h2A, 3'd1, 1'b1, 8, 11, 0, "flush_accept");
    do_req(0, 4'd9, 16'h1234, 25'h1000000, 6'h2A, 3'd4, 1'b0, 0, 3, 0, "post_flush_clean");
    @(negedge clk); flush[0] = 1'b1;
    @(negedge clk); flush[0] = 1'b0;
    m_valid[0] = 1'b0;
    do_req(0, 4'd9, 16'h1234, 25'h1000000, 6'h2A, 3'd7, 1'b0, 8, 11, 0, "flush_idle");
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_scanline[u] = '0; req_bitmap[u] = '0; req_attr[u] = '0;
      req_ctrl[u] = '0; req_phase[u] = '0; flush[u] = 1'b0; rsp_ready[u] = 1'b1;
      m_valid[u] = 1'b0; m_shadow[u] = '0;
    end
    test_reset();
    test_dirty_writes();
    test_backpressure();
    test_read_wait();
    test_abort();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
